// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the video/CPU RAM port arbiter.
// States, requester IDs and streak counter width.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  localparam logic REQ_VID = 1'b0;
  localparam logic REQ_CPU = 1'b1;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between requesters, arbiter and RAM port.
// master = requester/RAM side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ram_q,
    input  vid_ack, vid_rdata,
    input  cpu_ack, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ram_q,
    output vid_ack, vid_rdata,
    output cpu_ack, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Video/CPU arbiter and 4-cycle sequencer for one RAM port.
// Video has priority, bounded by a CPU starvation guard.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int VID_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  ram_port_arbiter_if.slave bus,
  output logic busy
);

  localparam logic [STREAK_W-1:0] BURST =
    STREAK_W'(VID_BURST);

  state_t              state;
  state_t              state_nxt;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nxt;
  logic                grant;
  logic                cpu_win;
  logic                win_id;

  // Next state, arbitration and streak update
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    grant      = 1'b0;
    cpu_win    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.vid_req || bus.cpu_req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          cpu_win   = bus.cpu_req &&
                      (!bus.vid_req || streak == BURST);
          if (!cpu_win && bus.cpu_req) begin
            if (streak != BURST)
              streak_nxt = streak + 1'b1;
          end else begin
            streak_nxt = '0;
          end
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and streak registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Winner latch; RAM port registers double as addr/wdata latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_id        <= REQ_VID;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else if (grant) begin
      win_id     <= cpu_win ? REQ_CPU : REQ_VID;
      bus.ram_en <= 1'b1;
      bus.ram_we <= cpu_win & bus.cpu_we;
      bus.ram_addr <= cpu_win ? bus.cpu_addr
                              : bus.vid_addr;
      if (cpu_win)
        bus.ram_wdata <= bus.cpu_wdata;
    end else begin
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
    end
  end

  // Capture read data in WAIT and pulse the winner's ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.vid_ack   <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.vid_rdata <= '0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      if (state == WAIT) begin
        if (win_id == REQ_CPU) begin
          bus.cpu_rdata <= bus.ram_q;
          bus.cpu_ack   <= 1'b1;
        end else begin
          bus.vid_rdata <= bus.ram_q;
          bus.vid_ack   <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a
// registered read-before-write RAM model.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:65535];

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .VID_BURST(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle registered read, old data on write
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_q <= mem[bus.ram_addr];
      if (bus.ram_we)
        mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ram_q     = '0;
    step();
    step();
    checks++;
    if ({bus.ram_en, bus.ram_we, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl en/we/busy=%b want 000",
               {bus.ram_en, bus.ram_we, busy});
    end
    checks++;
    if ({bus.vid_ack, bus.cpu_ack} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack got %b want 00",
               {bus.vid_ack, bus.cpu_ack});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata,
         bus.vid_rdata, bus.cpu_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h wd=%h vr=%h cr=%h want 0",
               bus.ram_addr, bus.ram_wdata,
               bus.vid_rdata, bus.cpu_rdata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_vid_read();
    mem[16'h1234] = 8'h5A;
    bus.vid_addr  = 16'h1234;
    bus.vid_req   = 1'b1;
    step();
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_addr !== 16'h1234 ||
        bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL vid_issue en=%b we=%b addr=%h want 1 0 1234",
               bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    step();
    checks++;
    if (bus.ram_en !== 1'b0 || bus.vid_ack !== 1'b0) begin
      errors++;
      $display("FAIL vid_wait en=%b ack=%b want 0 0",
               bus.ram_en, bus.vid_ack);
    end
    step();
    checks++;
    if (bus.vid_ack !== 1'b1 || bus.vid_rdata !== 8'h5A ||
        bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL vid_ack ack=%b rd=%h cack=%b want 1 5a 0",
               bus.vid_ack, bus.vid_rdata, bus.cpu_ack);
    end
    step();
    checks++;
    if (bus.vid_ack !== 1'b0 || busy !== 1'b0 ||
        bus.vid_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL vid_done ack=%b busy=%b rd=%h want 0 0 5a",
               bus.vid_ack, busy, bus.vid_rdata);
    end
    bus.vid_req = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    int we_cnt;
    mem[16'h0400] = 8'h11;
    bus.cpu_addr  = 16'h0400;
    bus.cpu_wdata = 8'hC3;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.ram_we === 1'b1) we_cnt++;
      if (i == 2) begin
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h11 ||
            bus.vid_ack !== 1'b0) begin
          errors++;
          $display("FAIL cpu_wr_ack ack=%b rd=%h vack=%b want 1 11 0",
                   bus.cpu_ack, bus.cpu_rdata, bus.vid_ack);
        end
      end
    end
    checks++;
    if (we_cnt != 1) begin
      errors++;
      $display("FAIL cpu_we_cycles got %0d want 1", we_cnt);
    end
    bus.cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) begin
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hC3) begin
          errors++;
          $display("FAIL cpu_rd_ack ack=%b rd=%h want 1 c3",
                   bus.cpu_ack, bus.cpu_rdata);
        end
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    int tv;
    int tc;
    tv = -1;
    tc = -1;
    mem[16'h0100] = 8'h21;
    mem[16'h0200] = 8'h42;
    bus.vid_addr = 16'h0100;
    bus.cpu_addr = 16'h0200;
    bus.cpu_we   = 1'b0;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (bus.vid_ack === 1'b1 && tv < 0) begin
        tv = s;
        bus.vid_req = 1'b0;
      end
      if (bus.cpu_ack === 1'b1 && tc < 0) begin
        tc = s;
        bus.cpu_req = 1'b0;
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    checks++;
    if (tv != 3) begin
      errors++;
      $display("FAIL sim_vid_first ack step %0d want 3", tv);
    end
    checks++;
    if (tc != 7) begin
      errors++;
      $display("FAIL sim_cpu_after ack step %0d want 7", tc);
    end
    checks++;
    if (bus.cpu_rdata !== 8'h42 || bus.vid_rdata !== 8'h21) begin
      errors++;
      $display("FAIL sim_data vr=%h cr=%h want 21 42",
               bus.vid_rdata, bus.cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic seq [20];
    int n;
    n = 0;
    mem[16'h0010] = 8'h01;
    mem[16'h0020] = 8'h02;
    bus.vid_addr = 16'h0010;
    bus.cpu_addr = 16'h0020;
    bus.cpu_we   = 1'b0;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    for (int s = 0; s < 120 && n < 20; s++) begin
      step();
      if (bus.vid_ack === 1'b1 && n < 20) begin
        seq[n] = 1'b0;
        n++;
      end
      if (bus.cpu_ack === 1'b1 && n < 20) begin
        seq[n] = 1'b1;
        n++;
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL burst_count got %0d grants want 20", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (seq[k] !== ((k % 5) == 4)) begin
        errors++;
        $display("FAIL burst_order grant %0d got %s want %s", k,
                 seq[k] ? "C" : "V", ((k % 5) == 4) ? "C" : "V");
      end
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int ack_seen;
    int tc;
    mem[16'h0555] = 8'h77;
    bus.cpu_addr  = 16'h0555;
    bus.cpu_wdata = 8'hEE;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    step();
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue en=%b we=%b want 1 1",
               bus.ram_en, bus.ram_we);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.ram_en !== 1'b0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_async en=%b we=%b busy=%b want 0 0 0",
               bus.ram_en, bus.ram_we, busy);
    end
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.cpu_ack === 1'b1 || bus.vid_ack === 1'b1)
        ack_seen++;
    end
    checks++;
    if (ack_seen != 0) begin
      errors++;
      $display("FAIL abort_no_ack got %0d acks want 0", ack_seen);
    end
    checks++;
    if (mem[16'h0555] !== 8'h77) begin
      errors++;
      $display("FAIL abort_mem got %h want 77", mem[16'h0555]);
    end
    reset = 1'b0;
    tc = -1;
    for (int s = 1; s <= 8 && tc < 0; s++) begin
      step();
      if (bus.cpu_ack === 1'b1) tc = s;
    end
    checks++;
    if (tc != 3) begin
      errors++;
      $display("FAIL abort_retry ack step %0d want 3", tc);
    end
    checks++;
    if (bus.cpu_rdata !== 8'h77) begin
      errors++;
      $display("FAIL abort_retry_rd got %h want 77", bus.cpu_rdata);
    end
    step();
    bus.cpu_req = 1'b0;
    checks++;
    if (mem[16'h0555] !== 8'hEE) begin
      errors++;
      $display("FAIL abort_retry_mem got %h want ee", mem[16'h0555]);
    end
  endtask

  initial begin
    test_reset();
    test_vid_read();
    test_cpu_write_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
